// File: rtl/mpc_mul_arb.sv
// mpc_mul_arb: shares one NUM_STAGE-deep pipelined multiplier among NUM_REQ requesters.
// Build option: define MPC_MUL_ARB_FIXED_PRIO_EN for fixed lowest-index priority (default round-robin).
module mpc_mul_arb #(
   parameter int NUM_REQ    = 4,
   parameter int DIN0_WIDTH = 21,
   parameter int DIN1_WIDTH = 8,
   parameter int DOUT_WIDTH = 29,
   parameter int NUM_STAGE  = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             ce,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_a,
   input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_b,
   output logic                             mul_ce,
   output logic [DIN0_WIDTH-1:0]            mul_din0,
   output logic [DIN1_WIDTH-1:0]            mul_din1,
   input  logic [DOUT_WIDTH-1:0]            mul_dout,
   output logic [NUM_REQ-1:0]               rsp_valid,
   output logic [DOUT_WIDTH-1:0]            rsp_data,
   output logic                             busy
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic                 grant_any;
   logic [IW-1:0]        grant_idx;
   logic [NUM_REQ-1:0]   grant_oh;
   logic                 xfer;
   logic                 rsp_fire;
   logic [NUM_STAGE-1:0] tag_vld_q, tag_vld_d;
   logic [IW-1:0]        tag_idx_q [NUM_STAGE];
   logic [IW-1:0]        tag_idx_d [NUM_STAGE];

`ifndef MPC_MUL_ARB_FIXED_PRIO_EN
   logic [IW-1:0] ptr_q, ptr_d;

   function automatic logic [IW-1:0] rr_slot(input logic [IW-1:0] base, input int unsigned ofs);
      int unsigned s;
      s = 32'(base) + ofs;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return s[IW-1:0];
   endfunction

   // Search starts at the pointer so the requester after the last winner goes first.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!grant_any && req_valid[rr_slot(ptr_q, k)]) begin
            grant_any = 1'b1;
            grant_idx = rr_slot(ptr_q, k);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (xfer) ptr_d = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end
`else
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!grant_any && req_valid[k]) begin
            grant_any = 1'b1;
            grant_idx = IW'(k);
         end
      end
   end
`endif

   always_comb begin
      xfer                = ce & ~reset & grant_any;
      grant_oh            = '0;
      grant_oh[grant_idx] = grant_any;
      req_ready           = xfer ? grant_oh : '0;
      mul_ce              = ce;
      mul_din0            = '0;
      mul_din1            = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (xfer && grant_idx == IW'(k)) begin
            mul_din0 = req_a[k*DIN0_WIDTH +: DIN0_WIDTH];
            mul_din1 = req_b[k*DIN1_WIDTH +: DIN1_WIDTH];
         end
      end
   end

   // Tags shadow the multiplier pipeline and freeze with it when ce is low.
   always_comb begin
      tag_vld_d = tag_vld_q;
      tag_idx_d = tag_idx_q;
      if (ce) begin
         tag_vld_d[0] = xfer;
         tag_idx_d[0] = grant_idx;
         for (int unsigned s = 1; s < NUM_STAGE; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_idx_d[s] = tag_idx_q[s-1];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_vld_q <= '0;
         for (int unsigned s = 0; s < NUM_STAGE; s++) tag_idx_q[s] <= '0;
      end else begin
         tag_vld_q <= tag_vld_d;
         tag_idx_q <= tag_idx_d;
      end
   end

   always_comb begin
      rsp_fire  = ce & ~reset & tag_vld_q[NUM_STAGE-1];
      rsp_valid = '0;
      if (rsp_fire) rsp_valid[tag_idx_q[NUM_STAGE-1]] = 1'b1;
      rsp_data  = rsp_fire ? mul_dout : '0;
      busy      = |tag_vld_q;
   end

endmodule

// File: tb/tb_mpc_mul_arb.sv
// tb_mpc_mul_arb: directed and randomized checks of mpc_mul_arb with a behavioural multiplier stand-in.
// Expectations follow MPC_MUL_ARB_FIXED_PRIO_EN the same way the design does.
module tb_mpc_mul_arb;
   localparam int NR = 4;
   localparam int W0 = 21;
   localparam int W1 = 8;
   localparam int WO = 29;
   localparam int NS = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              ce;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR*W0-1:0]  req_a;
   logic [NR*W1-1:0]  req_b;
   logic              mul_ce;
   logic [W0-1:0]     mul_din0;
   logic [W1-1:0]     mul_din1;
   logic [WO-1:0]     mul_dout;
   logic [NR-1:0]     rsp_valid;
   logic [WO-1:0]     rsp_data;
   logic              busy;

   int a_op [NR];
   int b_op [NR];
   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {int idx; int prod; int left;} rec_t;
   rec_t inflight[$];
`ifndef MPC_MUL_ARB_FIXED_PRIO_EN
   int m_ptr;
`endif

   always #5 clk = ~clk;

   mpc_mul_arb #(
      .NUM_REQ(NR), .DIN0_WIDTH(W0), .DIN1_WIDTH(W1), .DOUT_WIDTH(WO), .NUM_STAGE(NS)
   ) dut (
      .clk(clk), .reset(reset), .ce(ce),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
   );

   // External multiplier stand-in: not reset, so stale products stay visible.
   logic [WO-1:0] mpipe [NS];
   function automatic logic [WO-1:0] mulf(input logic [W0-1:0] a, input logic [W1-1:0] b);
      int p;
      p = $signed(a) * $signed(b);
      return p[WO-1:0];
   endfunction
   always @(posedge clk) begin
      if (mul_ce) begin
         for (int s = NS - 1; s > 0; s--) mpipe[s] <= mpipe[s-1];
         mpipe[0] <= mulf(mul_din0, mul_din1);
      end
   end
   assign mul_dout = mpipe[NS-1];

   function automatic logic [NR-1:0] onehot(input int i);
      logic [NR-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic load_ops();
      for (int i = 0; i < NR; i++) begin
         req_a[i*W0 +: W0] = a_op[i][W0-1:0];
         req_b[i*W1 +: W1] = b_op[i][W1-1:0];
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; ce = 1'b1; req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      inflight.delete();
`ifndef MPC_MUL_ARB_FIXED_PRIO_EN
      m_ptr = 0;
`endif
   endtask

   task automatic test_reset();
      for (int i = 0; i < NR; i++) begin a_op[i] = i + 5; b_op[i] = 3; end
      load_ops();
      reset = 1'b1; ce = 1'b1; req_valid = '1;
      @(negedge clk);
      @(negedge clk);
      #1;
      n_checks++; if (req_ready !== 4'b0000) $display("FAIL reset_ready got=%b exp=0000", req_ready); else n_pass++;
      n_checks++; if (rsp_valid !== 4'b0000) $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); else n_pass++;
      n_checks++; if (rsp_data !== '0) $display("FAIL reset_rsp_data got=%0h exp=0", rsp_data); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
      reset = 1'b0; req_valid = '0;
      @(negedge clk);
   endtask

   task automatic test_single();
      logic [NR-1:0] er, erv;
      logic [WO-1:0] erd;
      logic [W0-1:0] ea;
      logic [W1-1:0] eb;
      do_reset();
      a_op[0] = -3; b_op[0] = 5;
      load_ops();
      for (int cyc = 0; cyc < 8; cyc++) begin
         ce = 1'b1;
         req_valid = (cyc == 0) ? 4'b0001 : 4'b0000;
         #1;
         er  = (cyc == 0) ? 4'b0001 : 4'b0000;
         ea  = (cyc == 0) ? W0'(-3) : W0'(0);
         eb  = (cyc == 0) ? W1'(5) : W1'(0);
         erv = (cyc == 4) ? 4'b0001 : 4'b0000;
         erd = (cyc == 4) ? WO'(-15) : WO'(0);
         n_checks++; if (req_ready !== er) $display("FAIL single_ready cyc=%0d got=%b exp=%b", cyc, req_ready, er); else n_pass++;
         n_checks++; if (mul_din0 !== ea || mul_din1 !== eb) $display("FAIL single_din cyc=%0d got=%0h/%0h exp=%0h/%0h", cyc, mul_din0, mul_din1, ea, eb); else n_pass++;
         n_checks++; if (rsp_valid !== erv) $display("FAIL single_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, erv); else n_pass++;
         n_checks++; if (rsp_data !== erd) $display("FAIL single_rsp_data cyc=%0d got=%0h exp=%0h", cyc, rsp_data, erd); else n_pass++;
         n_checks++; if (busy !== (cyc >= 1 && cyc <= 4)) $display("FAIL single_busy cyc=%0d got=%b exp=%b", cyc, busy, (cyc >= 1 && cyc <= 4)); else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      logic [NR-1:0] er, erv;
      logic [WO-1:0] erd;
      do_reset();
      for (int i = 0; i < NR; i++) begin a_op[i] = i + 1; b_op[i] = 2; end
      load_ops();
      for (int cyc = 0; cyc < 12; cyc++) begin
         ce = 1'b1; req_valid = 4'b1111;
         #1;
`ifdef MPC_MUL_ARB_FIXED_PRIO_EN
         er  = 4'b0001;
         erv = (cyc >= 4) ? 4'b0001 : 4'b0000;
         erd = (cyc >= 4) ? WO'(2) : WO'(0);
`else
         er  = onehot(cyc % 4);
         erv = (cyc >= 4) ? onehot((cyc - 4) % 4) : 4'b0000;
         erd = (cyc >= 4) ? WO'(2 * ((cyc - 4) % 4 + 1)) : WO'(0);
`endif
         n_checks++; if (req_ready !== er) $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", cyc, req_ready, er); else n_pass++;
         n_checks++; if (rsp_valid !== erv) $display("FAIL b2b_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, erv); else n_pass++;
         n_checks++; if (rsp_data !== erd) $display("FAIL b2b_rsp_data cyc=%0d got=%0h exp=%0h", cyc, rsp_data, erd); else n_pass++;
         n_checks++; if (busy !== (cyc >= 1)) $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", cyc, busy, (cyc >= 1)); else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_stall();
      logic [NR-1:0] er, erv;
      logic [WO-1:0] erd;
      do_reset();
      a_op[2] = -9; b_op[2] = 11;
      load_ops();
      for (int cyc = 0; cyc < 11; cyc++) begin
         ce = !(cyc >= 2 && cyc <= 4);
         req_valid = (cyc == 0) ? 4'b0100 : (cyc == 3) ? 4'b0001 : 4'b0000;
         #1;
         er  = (cyc == 0) ? 4'b0100 : 4'b0000;
         erv = (cyc == 7) ? 4'b0100 : 4'b0000;
         erd = (cyc == 7) ? WO'(-99) : WO'(0);
         n_checks++; if (req_ready !== er) $display("FAIL stall_ready cyc=%0d got=%b exp=%b", cyc, req_ready, er); else n_pass++;
         n_checks++; if (mul_ce !== ce) $display("FAIL stall_mul_ce cyc=%0d got=%b exp=%b", cyc, mul_ce, ce); else n_pass++;
         n_checks++; if (rsp_valid !== erv) $display("FAIL stall_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, erv); else n_pass++;
         n_checks++; if (rsp_data !== erd) $display("FAIL stall_rsp_data cyc=%0d got=%0h exp=%0h", cyc, rsp_data, erd); else n_pass++;
         n_checks++; if (busy !== (cyc >= 1 && cyc <= 7)) $display("FAIL stall_busy cyc=%0d got=%b exp=%b", cyc, busy, (cyc >= 1 && cyc <= 7)); else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_extreme();
      logic [NR-1:0] erv;
      logic [WO-1:0] erd;
      do_reset();
      a_op[1] = -1048576; b_op[1] = -128;
      load_ops();
      for (int cyc = 0; cyc < 6; cyc++) begin
         ce = 1'b1;
         req_valid = (cyc == 0) ? 4'b0010 : 4'b0000;
         #1;
         erv = (cyc == 4) ? 4'b0010 : 4'b0000;
         erd = (cyc == 4) ? WO'(134217728) : WO'(0);
         if (cyc == 0) begin
            n_checks++; if (mul_din0 !== 21'h100000 || mul_din1 !== 8'h80) $display("FAIL extreme_din got=%0h/%0h exp=100000/80", mul_din0, mul_din1); else n_pass++;
         end
         n_checks++; if (rsp_valid !== erv) $display("FAIL extreme_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, erv); else n_pass++;
         n_checks++; if (rsp_data !== erd) $display("FAIL extreme_rsp_data cyc=%0d got=%0h exp=%0h", cyc, rsp_data, erd); else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset_midflight();
      do_reset();
      a_op[0] = 7; b_op[0] = 3; a_op[1] = 5; b_op[1] = -2;
      load_ops();
      ce = 1'b1; req_valid = 4'b0011;
      #1;
      n_checks++; if (req_ready !== 4'b0001) $display("FAIL midrst_ready0 got=%b exp=0001", req_ready); else n_pass++;
      @(negedge clk);
      req_valid = 4'b0010;
      #1;
      n_checks++; if (req_ready !== 4'b0010) $display("FAIL midrst_ready1 got=%b exp=0010", req_ready); else n_pass++;
      @(negedge clk);
      req_valid = 4'b0000;
      #1;
      reset = 1'b1;
      #1;
      n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy_in_reset got=%b exp=0", busy); else n_pass++;
      @(negedge clk);
      reset = 1'b0;
      for (int cyc = 3; cyc < 11; cyc++) begin
         req_valid = (cyc == 10) ? 4'b1111 : 4'b0000;
         #1;
         n_checks++; if (rsp_valid !== 4'b0000) $display("FAIL midrst_rsp_valid cyc=%0d got=%b exp=0000", cyc, rsp_valid); else n_pass++;
         if (cyc == 10) begin
            n_checks++; if (req_ready !== 4'b0001) $display("FAIL midrst_ptr_restart got=%b exp=0001", req_ready); else n_pass++;
         end
         @(negedge clk);
      end
      req_valid = '0;
   endtask

   task automatic test_random();
      int g, c, start;
      logic [NR-1:0] er, erv;
      logic [WO-1:0] erd;
      logic [W0-1:0] ea;
      logic [W1-1:0] eb;
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         ce = ($urandom_range(0, 3) != 0);
         req_valid = NR'($urandom);
         if ($urandom_range(0, 3) == 0 || cyc == 0) begin
            for (int i = 0; i < NR; i++) begin
               a_op[i] = int'($urandom) >>> 11;
               b_op[i] = int'($urandom) >>> 24;
            end
         end
         load_ops();
         #1;
`ifdef MPC_MUL_ARB_FIXED_PRIO_EN
         start = 0;
`else
         start = m_ptr;
`endif
         g = -1;
         if (ce) begin
            for (int k = 0; k < NR; k++) begin
               c = (start + k) % NR;
               if (g < 0 && req_valid[c]) g = c;
            end
         end
         er = '0; ea = '0; eb = '0;
         if (g >= 0) begin
            er = onehot(g); ea = W0'(a_op[g]); eb = W1'(b_op[g]);
         end
         erv = '0; erd = '0;
         if (ce && inflight.size() > 0 && inflight[0].left == 0) begin
            erv = onehot(inflight[0].idx); erd = WO'(inflight[0].prod);
         end
         n_checks++; if (req_ready !== er) $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, req_ready, er); else n_pass++;
         n_checks++; if (mul_din0 !== ea || mul_din1 !== eb) $display("FAIL rnd_din cyc=%0d got=%0h/%0h exp=%0h/%0h", cyc, mul_din0, mul_din1, ea, eb); else n_pass++;
         n_checks++; if (mul_ce !== ce) $display("FAIL rnd_mul_ce cyc=%0d got=%b exp=%b", cyc, mul_ce, ce); else n_pass++;
         n_checks++; if (rsp_valid !== erv) $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, erv); else n_pass++;
         n_checks++; if (rsp_data !== erd) $display("FAIL rnd_rsp_data cyc=%0d got=%0h exp=%0h", cyc, rsp_data, erd); else n_pass++;
         n_checks++; if (busy !== (inflight.size() != 0)) $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, (inflight.size() != 0)); else n_pass++;
         if (ce) begin
            if (inflight.size() > 0 && inflight[0].left == 0) void'(inflight.pop_front());
            foreach (inflight[j]) inflight[j].left--;
            if (g >= 0) begin
               inflight.push_back('{idx: g, prod: a_op[g] * b_op[g], left: NS - 1});
`ifndef MPC_MUL_ARB_FIXED_PRIO_EN
               m_ptr = (g + 1) % NR;
`endif
            end
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      reset = 1'b1; ce = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
      @(negedge clk);
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_extreme();
      test_reset_midflight();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/mpc_mul_arb.md
MPC_MUL_ARB -- requirements
Module: mpc_mul_arb

Interface
- REQ-001 Parameters SHALL be, one per line:
  - NUM_REQ, 4, number of requesters (2..8).
  - DIN0_WIDTH, 21, signed multiplicand width.
  - DIN1_WIDTH, 8, signed multiplier width.
  - DOUT_WIDTH, 29, product width.
  - NUM_STAGE, 4, multiplier pipeline latency in cycles.
- REQ-002 Ports SHALL be, one per line:
  - clk  in  1  single clock, rising edge.
  - reset  in  1  asynchronous, active-high reset.
  - ce  in  1  global clock enable; low freezes the block and the multiplier.
  - req_valid  in  NUM_REQ  per-requester request.
  - req_ready  out  NUM_REQ  per-requester grant/accept.
  - req_a  in  NUM_REQ*DIN0_WIDTH  packed signed operands A, requester i at slice i.
  - req_b  in  NUM_REQ*DIN1_WIDTH  packed signed operands B.
  - mul_ce  out  1  enable to the shared multiplier.
  - mul_din0  out  DIN0_WIDTH  operand A to the multiplier.
  - mul_din1  out  DIN1_WIDTH  operand B to the multiplier.
  - mul_dout  in  DOUT_WIDTH  multiplier product, NUM_STAGE cycles after the operands.
  - rsp_valid  out  NUM_REQ  one-hot result strobe.
  - rsp_data  out  DOUT_WIDTH  product routed to the requester flagged in rsp_valid.
  - busy  out  1  high while any operation is in flight.

Function
- REQ-003 The block SHALL share one NUM_STAGE-deep pipelined multiplier among NUM_REQ requesters and accept at most one operation per ce-high cycle.
- REQ-004 The arbiter SHALL compute grant combinationally from req_valid and the priority pointer; req_ready[i] SHALL equal ce AND grant[i], and at most one req_ready bit SHALL be high at a time.
- REQ-005 A transfer SHALL occur when req_valid[i] and req_ready[i] are both high.
- REQ-006 On a transfer, mul_din0/mul_din1 SHALL carry slice i of req_a/req_b in the same cycle; when there is no transfer they SHALL be driven to zero.
- REQ-007 mul_ce SHALL equal ce.
- REQ-008 A tag pipeline of NUM_STAGE entries SHALL advance only when ce is high; each entry SHALL hold a valid bit and a requester index.
- REQ-009 rsp_valid[t] SHALL be high for exactly one ce-high cycle, NUM_STAGE ce-high cycles after the transfer, where t is the tag in the last tag stage.
- REQ-010 rsp_data SHALL equal mul_dout in that cycle and 0 otherwise.
- REQ-011 When ce is low, rsp_valid SHALL be all-zero, no transfer SHALL occur, and tag and pointer state SHALL hold, so no result is duplicated or lost.
- REQ-012 The default arbitration SHALL be round-robin: after a transfer from requester i, the pointer SHALL become (i+1) mod NUM_REQ; with no transfer the pointer SHALL hold.
- REQ-013 Back-to-back transfers SHALL be sustained at one per ce-high cycle with no bubble.
- REQ-014 A request SHALL be accepted in the same cycle as a result returns to that same requester.
- REQ-015 busy SHALL be the OR of all tag-stage valid bits and SHALL be registered state only (independent of req_valid).
- REQ-016 Products SHALL be signed DIN0_WIDTH x DIN1_WIDTH; the block SHALL pass mul_dout through unmodified with no saturation.

Reset
- REQ-017 While reset is high:
  - all tag-stage valid bits SHALL clear;
  - the pointer SHALL be 0;
  - req_ready, rsp_valid, rsp_data and busy SHALL read 0.
- REQ-018 Operations in flight when reset asserts SHALL be discarded and SHALL NOT produce rsp_valid after reset releases, even if mul_dout still carries stale products.

Configuration
- REQ-019 With macro MPC_MUL_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority: the lowest asserted index wins, and the pointer register SHALL NOT be implemented.
- REQ-020 With MPC_MUL_ARB_FIXED_PRIO_EN undefined, round-robin per REQ-012 SHALL apply.
- REQ-021 All other behaviour SHALL be identical in both builds.

Verification
- REQ-022 Single request:
  - stimulus: req0 with a=-3, b=5 at cycle 0, ce=1;
  - response: req_ready[0]=1 at cycle 0; rsp_valid=0001 and rsp_data=-15 at cycle 4; busy high over cycles 1..4.
- REQ-023 All four requesting continuously (round-robin build), a_i=i+1, b_i=2:
  - grant order 0,1,2,3,0,...;
  - results 2,4,6,8 on rsp_valid 0001,0010,0100,1000 at cycles 4..7.
- REQ-024 Same stimulus (fixed-priority build):
  - req0 is granted every cycle;
  - req1..req3 never see req_ready.
- REQ-025 Stall:
  - stimulus: transfer at cycle 0, then ce=0 during cycles 2..4;
  - response: rsp_valid appears exactly once, at cycle 7, with no duplicate during the stall.
- REQ-026 Extreme operands: a=-1048576, b=-128 -> rsp_data=134217728.
- REQ-027 Reset mid-flight:
  - stimulus: reset pulsed at cycle 2 after transfers at cycles 0 and 1;
  - response: no rsp_valid at any later cycle; pointer restarts at 0.
